// File: rtl/button_debounce_if.sv
// Memory-bus slave port of button_debounce: OR-combined read data and a zero-wait ready.
interface button_debounce_if;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  modport master (
    output address_in, sel_in, read_in, write_mask_in, write_value_in,
    input  read_value_out, ready_out
  );

  modport slave (
    input  address_in, sel_in, read_in, write_mask_in, write_value_in,
    output read_value_out, ready_out
  );
endinterface

// File: rtl/button_debounce.sv
// Debounced, memory-mapped button port: 2-FF sync, per-bit hold counter, sticky W1C edge flags.
// Optional BUTTON_IRQ_EN adds the IRQ_MASK register and a registered level interrupt.
module button_debounce #(
  parameter int WIDTH        = 4,
  parameter int CNT_WIDTH    = 20,
  parameter int DEBOUNCE_RST = 36000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] buttons_in,
  button_debounce_if.slave bus,
  output logic             irq_out
);

  localparam logic [1:0]           OFF_STATE  = 2'd0;
  localparam logic [1:0]           OFF_EDGE   = 2'd1;
  localparam logic [1:0]           OFF_THRESH = 2'd2;
  localparam logic [1:0]           OFF_MASK   = 2'd3;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  logic [WIDTH-1:0]     r_sync1, r_sync2, r_stable, r_rise, r_fall;
  logic [CNT_WIDTH-1:0] r_cnt [WIDTH];
  logic [CNT_WIDTH-1:0] r_thresh;

  logic [WIDTH-1:0]     w_commit, w_rise_set, w_fall_set, w_clr_rise, w_clr_fall;
  logic                 w_wr, w_wr_edge, w_wr_thresh, w_wr_mask;
  logic [31:0]          w_bmask, w_thresh_word, w_mask_word, w_rdata;
  logic [CNT_WIDTH-1:0] w_thresh_next;
  logic                 w_unused;

  function automatic logic [31:0] pack_flags(input logic [WIDTH-1:0] lo, input logic [WIDTH-1:0] hi);
    logic [31:0] v;
    v            = 32'h0;
    v[WIDTH-1:0] = lo;
    v[16+:WIDTH] = hi;
    return v;
  endfunction

  // Bus write decode and byte-lane merge for the writable registers
  always_comb begin
    w_bmask       = {{8{bus.write_mask_in[3]}}, {8{bus.write_mask_in[2]}},
                     {8{bus.write_mask_in[1]}}, {8{bus.write_mask_in[0]}}};
    w_wr          = bus.sel_in & (|bus.write_mask_in);
    w_wr_edge     = w_wr & (bus.address_in[3:2] == OFF_EDGE);
    w_wr_thresh   = w_wr & (bus.address_in[3:2] == OFF_THRESH);
    w_wr_mask     = w_wr & (bus.address_in[3:2] == OFF_MASK);
    w_thresh_word = 32'(r_thresh);
    w_thresh_next = CNT_WIDTH'((w_thresh_word & ~w_bmask) | (bus.write_value_in & w_bmask));
    if (w_wr_edge) begin
      w_clr_rise = bus.write_value_in[WIDTH-1:0] & w_bmask[WIDTH-1:0];
      w_clr_fall = bus.write_value_in[16+:WIDTH] & w_bmask[16+:WIDTH];
    end else begin
      w_clr_rise = {WIDTH{1'b0}};
      w_clr_fall = {WIDTH{1'b0}};
    end
  end

  // Commit decision per bit; >= lets a lowered threshold commit a long-running count at once
  always_comb begin
    w_commit = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sync2[i] != r_stable[i]) begin
        if (r_thresh == CNT_ZERO) begin
          w_commit[i] = 1'b1;
        end else if (r_cnt[i] >= (r_thresh - CNT_ONE)) begin
          w_commit[i] = 1'b1;
        end else begin
          w_commit[i] = 1'b0;
        end
      end else begin
        w_commit[i] = 1'b0;
      end
    end
    w_rise_set = w_commit & r_sync2;
    w_fall_set = w_commit & ~r_sync2;
  end

  // Synchroniser, debounce counters, sticky edge flags (set beats clear) and threshold
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1  <= {WIDTH{1'b0}};
      r_sync2  <= {WIDTH{1'b0}};
      r_stable <= {WIDTH{1'b0}};
      r_rise   <= {WIDTH{1'b0}};
      r_fall   <= {WIDTH{1'b0}};
      r_thresh <= CNT_WIDTH'(DEBOUNCE_RST);
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
    end else begin
      r_sync1 <= buttons_in;
      r_sync2 <= r_sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= CNT_ZERO;
        end else if (w_commit[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= CNT_ZERO;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
      r_rise <= (r_rise & ~w_clr_rise) | w_rise_set;
      r_fall <= (r_fall & ~w_clr_fall) | w_fall_set;
      if (w_wr_thresh) begin
        r_thresh <= w_thresh_next;
      end else begin
        r_thresh <= r_thresh;
      end
    end
  end

`ifdef BUTTON_IRQ_EN
  logic [WIDTH-1:0] r_mask_rise, r_mask_fall;
  logic             r_irq;

  // Interrupt mask register and the registered interrupt level
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mask_rise <= {WIDTH{1'b0}};
      r_mask_fall <= {WIDTH{1'b0}};
      r_irq       <= 1'b0;
    end else begin
      if (w_wr_mask) begin
        r_mask_rise <= (r_mask_rise & ~w_bmask[WIDTH-1:0])
                     | (bus.write_value_in[WIDTH-1:0] & w_bmask[WIDTH-1:0]);
        r_mask_fall <= (r_mask_fall & ~w_bmask[16+:WIDTH])
                     | (bus.write_value_in[16+:WIDTH] & w_bmask[16+:WIDTH]);
      end else begin
        r_mask_rise <= r_mask_rise;
        r_mask_fall <= r_mask_fall;
      end
      r_irq <= |((r_rise & r_mask_rise) | (r_fall & r_mask_fall));
    end
  end

  assign w_mask_word = pack_flags(r_mask_rise, r_mask_fall);
  assign irq_out     = r_irq;
`else
  assign w_mask_word = 32'h0;
  assign irq_out     = 1'b0;
`endif

  // Combinational register read mux
  always_comb begin
    w_rdata = 32'h0;
    case (bus.address_in[3:2])
      OFF_STATE:  w_rdata = 32'(r_stable);
      OFF_EDGE:   w_rdata = pack_flags(r_rise, r_fall);
      OFF_THRESH: w_rdata = w_thresh_word;
      OFF_MASK:   w_rdata = w_mask_word;
      default:    w_rdata = 32'h0;
    endcase
  end

  // Deselected blocks must drive zero onto the shared OR read bus
  assign bus.read_value_out = bus.sel_in ? w_rdata : 32'h0;
  assign bus.ready_out      = bus.sel_in;

  assign w_unused = ^{bus.address_in, bus.read_in, bus.write_value_in, w_bmask, w_wr_mask};

endmodule
